mseq_chk: RTL and testbench

//  Receive-side checker for the Galois m-sequence (PRBS) generator. Self-synchronises to a serial

---
 rtl/mseq_chk.sv | 180 ++++++++++++++++++
 tb/tb_mseq_chk.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mseq_chk.sv
// mseq_chk: receive-side checker for a Galois m-sequence (PRBS) stream.
//
// It synchronises to the serial stream by predicting each bit from the last W bits.
// After LOCK_CNT consecutive correct predictions it declares lock. While locked it
// runs as a flywheel from its own prediction. It counts mismatches against that
// prediction. Lock is dropped when ERR_THR errors land inside one WIN-bit window.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   din        received PRBS bit
//   din_valid  din is sampled only when 1
//   clr        synchronous clear of err_cnt and bit_cnt
//   locked     1 while tracking the sequence
//   err_pulse  one-cycle pulse: the bit just checked while locked was wrong
//   lost_lock  one-cycle pulse: lock was dropped
//   err_cnt    saturating count of bit errors while locked
//   bit_cnt    saturating count of bits checked while locked
//
// state  | meaning
// -------+-------------------------------------------------------------
// SEARCH | filling history, then counting consecutive correct predictions
// LOCKED | flywheel on the local prediction, counting errors per window
module mseq_chk #(
    parameter int           W        = 4,
    parameter logic [W:0]   POLY     = 5'b10011,
    parameter int           LOCK_CNT = 16,
    parameter int           WIN      = 64,
    parameter int           ERR_THR  = 4,
    parameter int           CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             lost_lock,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int FILL_W  = $clog2(W + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN);
    localparam int WERR_W  = $clog2(ERR_THR + 1);

    // hist[0] is the oldest bit; tap k weights hist[k] with POLY[W-k].
    function automatic logic [W-1:0] taps_of(input logic [W:1] p);
        logic [W-1:0] t;
        for (int k = 0; k < W; k++) begin
            t[k] = p[W-k];
        end
        return t;
    endfunction

    localparam logic [W-1:0] TAPS = taps_of(POLY[W:1]);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_n;
    logic [W-1:0]        hist, hist_n;
    logic [FILL_W-1:0]   fill, fill_n;
    logic [MATCH_W-1:0]  match, match_n;
    logic [WIN_W-1:0]    win_rem, win_rem_n;   // bits left in the window, terminal count at 0
    logic [WERR_W-1:0]   werr, werr_n, werr_sum;
    logic [CNT_W-1:0]    err_cnt_n, bit_cnt_n;
    logic                locked_n, err_pulse_n, lost_lock_n;
    logic                pred, e;

    assign pred = ^(hist & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEARCH;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            win_rem   <= WIN_W'(WIN - 1);
            werr      <= '0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            state     <= state_n;
            hist      <= hist_n;
            fill      <= fill_n;
            match     <= match_n;
            win_rem   <= win_rem_n;
            werr      <= werr_n;
            err_cnt   <= err_cnt_n;
            bit_cnt   <= bit_cnt_n;
            locked    <= locked_n;
            err_pulse <= err_pulse_n;
            lost_lock <= lost_lock_n;
        end
    end

    always_comb begin
        state_n     = state;
        hist_n      = hist;
        fill_n      = fill;
        match_n     = match;
        win_rem_n   = win_rem;
        werr_n      = werr;
        err_cnt_n   = err_cnt;
        bit_cnt_n   = bit_cnt;
        locked_n    = locked;
        err_pulse_n = 1'b0;
        lost_lock_n = 1'b0;
        e           = 1'b0;
        werr_sum    = werr;

        if (din_valid) begin
            case (state)
                SEARCH: begin
                    hist_n = {din, hist[W-1:1]};
                    if (fill != FILL_W'(W)) begin
                        fill_n = fill + 1'b1;
                    end else if ((din == pred) && (hist != '0)) begin
                        match_n = match + 1'b1;
                        if (match == MATCH_W'(LOCK_CNT - 1)) begin
                            state_n   = LOCKED;
                            locked_n  = 1'b1;
                            win_rem_n = WIN_W'(WIN - 1);
                            werr_n    = '0;
                        end
                    end else begin
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    e      = din ^ pred;
                    // Flywheel: a line error must not corrupt the reference.
                    hist_n = {pred, hist[W-1:1]};
                    if (bit_cnt != '1) begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                    if (e) begin
                        err_pulse_n = 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt_n = err_cnt + 1'b1;
                        end
                    end
                    werr_sum = werr + WERR_W'(e);
                    // The threshold test comes before the window rollover so an
                    // error on the last bit of a window still counts.
                    if (werr_sum >= WERR_W'(ERR_THR)) begin
                        state_n     = SEARCH;
                        locked_n    = 1'b0;
                        lost_lock_n = 1'b1;
                        fill_n      = '0;
                        match_n     = '0;
                    end else if (win_rem == '0) begin
                        win_rem_n = WIN_W'(WIN - 1);
                        werr_n    = '0;
                    end else begin
                        win_rem_n = win_rem - 1'b1;
                        werr_n    = werr_sum;
                    end
                end
                default: begin
                    state_n = SEARCH;
                end
            endcase
        end

        if (clr) begin
            err_cnt_n = '0;
            bit_cnt_n = '0;
        end
    end

endmodule

// File: tb/tb_mseq_chk.sv
// tb_mseq_chk: testbench for mseq_chk with the default parameters (W=4, POLY=10011).
// A local generator produces the PRBS stream. The stimulus pushes the events it
// expects into a scoreboard. Each event records the valid-bit index, the counters
// and the lock state. A monitor pops an entry whenever the DUT shows lock rising,
// err_pulse or lost_lock.
module tb_mseq_chk;

    localparam int CNT_W = 16;
    localparam int EV_LOCK = 0;
    localparam int EV_ERR  = 1;
    localparam int EV_LOST = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             clr = 1'b0;
    logic             locked, err_pulse, lost_lock;
    logic [CNT_W-1:0] err_cnt, bit_cnt;

    mseq_chk dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .lost_lock (lost_lock),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int vidx;
        int ec;
        int bc;
        int lk;
    } ev_t;

    ev_t        sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         vcnt = 0;
    logic [3:0] sr = 4'b1001;
    logic       prev_locked = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int vidx, input int ec, input int bc, input int lk);
        ev_t e;
        e.kind = kind;
        e.vidx = vidx;
        e.ec   = ec;
        e.bc   = bc;
        e.lk   = lk;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: kind=%0d at valid bit %0d, none expected", kind, vcnt);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.vidx != vcnt || e.ec != int'(err_cnt) ||
                e.bc != int'(bit_cnt) || e.lk != int'(locked)) begin
                miscompares++;
                $display("FAIL event: got kind=%0d bit=%0d err_cnt=%0d bit_cnt=%0d locked=%0d, expected kind=%0d bit=%0d err_cnt=%0d bit_cnt=%0d locked=%0d",
                         kind, vcnt, err_cnt, bit_cnt, locked, e.kind, e.vidx, e.ec, e.bc, e.lk);
            end
        end
    endtask

    // Error is checked before lost_lock so the 4th-error cycle pops in push order.
    always @(negedge clk) begin
        if (err_pulse) check_ev(EV_ERR);
        if (lost_lock) check_ev(EV_LOST);
        if (locked && !prev_locked) check_ev(EV_LOCK);
        prev_locked = locked;
    end

    task automatic gen(output logic b);
        b  = sr[0];
        sr = {sr[0] ^ sr[3], sr[3:1]};
    endtask

    task automatic send_raw(input logic b, input logic v, input logic c);
        din       = b;
        din_valid = v;
        clr       = c;
        @(posedge clk);
        if (v) vcnt++;
        #1;
        din_valid = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic send_prbs(input logic inv, input logic c);
        logic b;
        gen(b);
        send_raw(b ^ inv, 1'b1, c);
    endtask

    task automatic drain(input string name);
        repeat (3) send_raw(1'b0, 1'b0, 1'b0);
        chk(name, sb.size(), 0);
    endtask

    task automatic do_reset(input string name);
        rst_n     = 1'b0;
        din_valid = 1'b0;
        clr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_locked"},    int'(locked),    0);
        chk({name, "_err_pulse"}, int'(err_pulse), 0);
        chk({name, "_lost_lock"}, int'(lost_lock), 0);
        chk({name, "_err_cnt"},   int'(err_cnt),   0);
        chk({name, "_bit_cnt"},   int'(bit_cnt),   0);
        rst_n = 1'b1;
        vcnt  = 0;
    endtask

    task automatic chk_status(input string name, input int lk, input int ec, input int bc);
        chk({name, "_locked"},  int'(locked),  lk);
        chk({name, "_err_cnt"}, int'(err_cnt), ec);
        chk({name, "_bit_cnt"}, int'(bit_cnt), bc);
    endtask

    initial begin
        int errs[9];
        int n;
        logic inv;
        errs = '{10, 20, 63, 64, 100, 127, 128, 150, 191};

        // 1: clean stream, lock after the 20th valid bit, then 1000 checked bits
        do_reset("t1_rst");
        expect_ev(EV_LOCK, 20, 0, 0, 1);
        repeat (20) send_prbs(1'b0, 1'b0);
        repeat (1000) send_prbs(1'b0, 1'b0);
        drain("t1_events");
        chk_status("t1", 1, 0, 1000);

        // 2: clear, then a single inverted bit
        send_raw(1'b0, 1'b0, 1'b1);
        chk_status("t2_clr", 1, 0, 0);
        repeat (9) send_prbs(1'b0, 1'b0);
        expect_ev(EV_ERR, vcnt + 1, 1, 10, 1);
        send_prbs(1'b1, 1'b0);
        repeat (100) send_prbs(1'b0, 1'b0);
        drain("t2_events");
        chk_status("t2", 1, 1, 110);

        // 3: four errors in one window drop lock, clean data relocks in 20 bits
        do_reset("t3_rst");
        expect_ev(EV_LOCK, 20, 0, 0, 1);
        repeat (20) send_prbs(1'b0, 1'b0);
        expect_ev(EV_ERR,  23, 1, 3, 1);
        expect_ev(EV_ERR,  25, 2, 5, 1);
        expect_ev(EV_ERR,  27, 3, 7, 1);
        expect_ev(EV_ERR,  29, 4, 9, 0);
        expect_ev(EV_LOST, 29, 4, 9, 0);
        expect_ev(EV_LOCK, 49, 4, 9, 1);
        for (int i = 0; i < 9; i++) send_prbs(i == 2 || i == 4 || i == 6 || i == 8, 1'b0);
        repeat (20) send_prbs(1'b0, 1'b0);
        drain("t3_events");
        chk_status("t3", 1, 4, 9);

        // 4: three errors per window, including the last bit of one window and the first of the next
        do_reset("t4_rst");
        expect_ev(EV_LOCK, 20, 0, 0, 1);
        repeat (20) send_prbs(1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            inv = 1'b0;
            foreach (errs[j]) if (errs[j] == i) inv = 1'b1;
            if (inv) begin
                n++;
                expect_ev(EV_ERR, vcnt + 1, n, i + 1, 1);
            end
            send_prbs(inv, 1'b0);
        end
        drain("t4_events");
        chk_status("t4", 1, 9, 200);

        // 5: all-zero stream never locks
        do_reset("t5_rst");
        repeat (200) send_raw(1'b0, 1'b1, 1'b0);
        drain("t5_events");
        chk_status("t5", 0, 0, 0);

        // 6: random valid gaps, lock point unchanged in valid-bit count
        do_reset("t6_rst");
        expect_ev(EV_LOCK, 20, 0, 0, 1);
        repeat (20) begin
            repeat ($urandom_range(0, 3)) send_raw(1'($urandom), 1'b0, 1'b0);
            send_prbs(1'b0, 1'b0);
        end
        repeat (50) begin
            repeat ($urandom_range(0, 3)) send_raw(1'($urandom), 1'b0, 1'b0);
            send_prbs(1'b0, 1'b0);
        end
        drain("t6_events");
        chk_status("t6", 1, 0, 50);

        // 7: clear on the same edge as an error
        expect_ev(EV_ERR, vcnt + 1, 0, 0, 1);
        send_prbs(1'b1, 1'b1);
        drain("t7_events");
        chk_status("t7", 1, 0, 0);
        send_prbs(1'b0, 1'b0);
        chk_status("t7_after", 1, 0, 1);

        // 8: reset while locked clears outputs without a clock edge, then relock
        rst_n = 1'b0;
        #1;
        chk_status("t8_async", 0, 0, 0);
        chk("t8_async_err_pulse", int'(err_pulse), 0);
        chk("t8_async_lost_lock", int'(lost_lock), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcnt  = 0;
        expect_ev(EV_LOCK, 20, 0, 0, 1);
        repeat (19) send_prbs(1'b0, 1'b0);
        chk("t8_not_yet_locked", int'(locked), 0);
        send_prbs(1'b0, 1'b0);
        drain("t8_events");
        chk_status("t8", 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
